// File: rtl/mult_bcd.sv
// mult_bcd: converts the 16-bit product {Aval,Bval} to five BCD digits plus
// a sign flag using sequential double-dabble (add-3 then shift, one bit per
// clock). One conversion is 1 accept edge plus 16 CONV edges.
// Optional build macro: MULT_BCD_LZB_EN turns on leading-zero blanking, so
// leading zero digits Bcd4..Bcd1 read 4'hF when a result is loaded.
module mult_bcd #(
    parameter bit SIGNED = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Aval,
    input  logic [7:0] Bval,
    output logic       Busy,
    output logic       Done,
    output logic       Neg,
    output logic [3:0] Bcd4,
    output logic [3:0] Bcd3,
    output logic [3:0] Bcd2,
    output logic [3:0] Bcd1,
    output logic [3:0] Bcd0
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [19:0] scratch;
    logic [15:0] bin;
    logic        neg_r;

    logic [15:0] prod;
    logic        prod_neg;
    logic [15:0] prod_mag;
    logic [19:0] adj;
    logic [35:0] sh;
    logic [19:0] digits;
    logic        lead;

    // Operand magnitude; 0x8000 negates to itself, which reads as 32768.
    always_comb begin
        prod     = {Aval, Bval};
        prod_neg = SIGNED && prod[15];
        prod_mag = prod_neg ? (~prod + 16'd1) : prod;
    end

    // Add-3 on every nibble >= 5, then shift scratch:bin left one place.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        sh = {adj, bin} << 1;
    end

    // Digits as loaded onto the outputs, optionally with leading zeros blanked.
    always_comb begin
        digits = sh[35:16];
        lead   = 1'b1;
`ifdef MULT_BCD_LZB_EN
        for (int i = 4; i >= 1; i--) begin
            if (lead && (sh[16 + 4*i +: 4] == 4'd0))
                digits[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
    end

    // Control FSM, scratch datapath and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            scratch <= 20'd0;
            bin     <= 16'd0;
            neg_r   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Neg     <= 1'b0;
            Bcd4    <= 4'd0;
            Bcd3    <= 4'd0;
            Bcd2    <= 4'd0;
            Bcd1    <= 4'd0;
            Bcd0    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        bin     <= prod_mag;
                        neg_r   <= prod_neg;
                        scratch <= 20'd0;
                        cnt     <= 4'd0;
                        Busy    <= 1'b1;
                        state   <= S_CONV;
                    end
                end
                default: begin
                    scratch <= sh[35:16];
                    bin     <= sh[15:0];
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        {Bcd4, Bcd3, Bcd2, Bcd1, Bcd0} <= digits;
                        Neg   <= neg_r;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
